// File: rtl/demux1to4_latch.sv
// demux1to4_latch: registered 1-to-4 demux with edge-detected manual load, auto-scan mode and saturating write counter
//   clock/reset : rising-edge clock, synchronous active-high reset
//   d, sel      : data to route and manual destination lane (sel[1] is the high select bit)
//   load        : level strobe, only its rising edge writes in manual mode
//   auto, tick  : auto-scan enable and single-cycle scan advance
//   clear       : zeroes lanes, valid flags and write count (scan pointer kept)
//   q, valid    : held lane outputs (lane k at q[k*WIDTH +: WIDTH]) and per-lane written flags
//   cur_sel     : lane the next write targets; wr_count : saturating write count
module demux1to4_latch #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   d,
  input  logic [1:0]         sel,
  input  logic               load,
  input  logic               auto,
  input  logic               tick,
  input  logic               clear,
  output logic [4*WIDTH-1:0] q,
  output logic [3:0]         valid,
  output logic [1:0]         cur_sel,
  output logic [CNT_W-1:0]   wr_count
);
  logic       load_prev;
  logic [1:0] ptr;
  logic       wr;
  logic [3:0] we;
  always_comb begin
    cur_sel = auto ? ptr : sel;
    wr      = auto ? tick : (load & ~load_prev);
    we      = wr ? (4'b0001 << cur_sel) : 4'b0000;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      q         <= '0;
      valid     <= '0;
      wr_count  <= '0;
      load_prev <= 1'b0;
      ptr       <= '0;
    end else begin
      load_prev <= load;
      // the pointer advances on every auto tick, even when clear drops the write
      if (auto && tick) ptr <= ptr + 2'd1;
      if (clear) begin
        q        <= '0;
        valid    <= '0;
        wr_count <= '0;
      end else if (wr) begin
        for (int k = 0; k < 4; k++)
          if (we[k]) q[k*WIDTH +: WIDTH] <= d;
        valid <= valid | we;
        if (wr_count != {CNT_W{1'b1}}) wr_count <= wr_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_demux1to4_latch.sv
// tb_demux1to4_latch: directed plus random checks of demux1to4_latch against a lane-array reference model
module tb_demux1to4_latch;
  logic       clock = 1'b0;
  logic       reset, d, load, auto, tick, clear;
  logic [1:0] sel;
  logic [3:0] q, valid, q2, valid2;
  logic [1:0] cur_sel, cur_sel2;
  logic [7:0] wr_count;
  logic [1:0] wr_count2;
  int passed = 0;
  int total = 0;
  logic [3:0] m_q, m_v;
  int m_cnt, m_cnt2, m_ptr;
  logic m_prev;

  always #5 clock = ~clock;

  demux1to4_latch #(.WIDTH(1), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .d(d), .sel(sel), .load(load), .auto(auto),
    .tick(tick), .clear(clear), .q(q), .valid(valid), .cur_sel(cur_sel), .wr_count(wr_count)
  );
  demux1to4_latch #(.WIDTH(1), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .d(d), .sel(sel), .load(load), .auto(auto),
    .tick(tick), .clear(clear), .q(q2), .valid(valid2), .cur_sel(cur_sel2), .wr_count(wr_count2)
  );

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  task automatic cyc(input logic r, input logic dd, input logic [1:0] s,
                     input logic l, input logic a, input logic t, input logic c);
    logic w;
    int tgt;
    @(negedge clock);
    reset = r; d = dd; sel = s; load = l; auto = a; tick = t; clear = c;
    #1;
    chk("cur_sel_pre", cur_sel, a ? m_ptr : s);
    if (r) begin
      m_q = 0; m_v = 0; m_cnt = 0; m_cnt2 = 0; m_ptr = 0; m_prev = 0;
    end else begin
      w = a ? t : (l && !m_prev);
      tgt = a ? m_ptr : s;
      m_prev = l;
      if (a && t) m_ptr = (m_ptr + 1) % 4;
      if (c) begin
        m_q = 0; m_v = 0; m_cnt = 0; m_cnt2 = 0;
      end else if (w) begin
        m_q[tgt] = dd;
        m_v[tgt] = 1'b1;
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    @(posedge clock);
    #1;
    chk("q", q, m_q);
    chk("valid", valid, m_v);
    chk("wr_count", wr_count, m_cnt);
    chk("wr_count_sat", wr_count2, m_cnt2);
    chk("cur_sel_post", cur_sel, a ? m_ptr : s);
  endtask

  initial begin
    m_q = 0; m_v = 0; m_cnt = 0; m_cnt2 = 0; m_ptr = 0; m_prev = 0;
    reset = 1; d = 0; sel = 0; load = 0; auto = 0; tick = 0; clear = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 3, 1, 1, 1, 0);
    chk("reset_q", q, 4'b0000);
    chk("reset_cnt", wr_count, 8'd0);
    // manual load rise to lane2
    cyc(0, 0, 2, 0, 0, 0, 0);
    cyc(0, 1, 2, 1, 0, 0, 0);
    chk("tp1_q", q, 4'b0100);
    chk("tp1_valid", valid, 4'b0100);
    chk("tp1_cnt", wr_count, 8'd1);
    // held load writes once, sel change while high does nothing
    cyc(0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 1, 0, 0, 0);
    chk("tp2_valid", valid, 4'b0110);
    chk("tp2_cnt", wr_count, 8'd2);
    cyc(0, 1, 3, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0);
    chk("tp2_hold", valid, 4'b0110);
    // auto scan after clear, five ticks
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, (i % 2 == 0), 2, 1, 1, 1, 0);
    chk("tp3_q", q, 4'b0101);
    chk("tp3_cnt", wr_count, 8'd5);
    chk("tp3_cur_sel", cur_sel, 2'd1);
    // clear with tick: write dropped, pointer advances
    cyc(0, 1, 0, 0, 1, 1, 1);
    chk("tp4_q", q, 4'b0000);
    chk("tp4_valid", valid, 4'b0000);
    chk("tp4_cnt", wr_count, 8'd0);
    chk("tp4_ptr", cur_sel, 2'd2);
    // narrow counter saturates
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 1, 1, 0);
    chk("tp5_sat", wr_count2, 2'd3);
    chk("tp5_cnt", wr_count, 8'd5);
    // reset mid-scan with ptr=2
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 1, 0);
    chk("tp6_ptr2", cur_sel, 2'd2);
    cyc(1, 1, 0, 0, 1, 1, 0);
    chk("tp6_ptr0", cur_sel, 2'd0);
    cyc(0, 1, 3, 0, 1, 1, 0);
    chk("tp6_q", q, 4'b0001);
    // manual mode keeps the pointer, auto resumes from it
    cyc(0, 1, 2, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("resume_ptr", cur_sel, 2'd1);
    // random traffic
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 40) == 0, 1'($urandom), 2'($urandom), 1'($urandom),
          $urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, 20) == 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/demux1to4_latch.md
Name: demux1to4_latch

Overview:
- Registered 1-to-4 demultiplexer. The receiving-end counterpart of the team's 2-level 4-to-1 mux.
- Routes one WIDTH-bit input onto one of four held output lanes, on a debounced-edge load strobe or in auto-scan mode.
- Sits between board switches/KEY and four LEDR groups. The inverse of the mux4to1 select path, so the same SW[9:8] select encoding drives both.

Parameters:
- WIDTH, 1, data bits per lane.
- CNT_W, 8, width of the saturating write counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- d  in  WIDTH  data to route.
- sel  in  2  destination lane in manual mode. Encoding: 00 to lane0, 01 to lane1, 10 to lane2, 11 to lane3. sel[1] is the outer/high select bit, as in the mux.
- load  in  1  level strobe. Only its 0-to-1 transition acts.
- auto  in  1  1 = auto-scan mode, 0 = manual mode.
- tick  in  1  single-cycle enable advancing the auto-scan pointer.
- clear  in  1  clears all lanes and valid flags.
- q  out  4*WIDTH  lane outputs. Lane k occupies q[k*WIDTH +: WIDTH].
- valid  out  4  valid[k] = lane k written since the last reset/clear.
- cur_sel  out  2  lane the next write will target.
- wr_count  out  CNT_W  number of writes, saturating.

Behaviour:
- Reset (clock edge with reset=1): q=0, valid=0, cur_sel=0, wr_count=0, internal load_prev=0, scan pointer=0. Reset overrides every other input.
- Edge detect: load_prev is registered from load each cycle. load_rise = load & ~load_prev. A load held high produces exactly one write.
- Manual mode (auto=0):
  - cur_sel = sel, combinationally.
  - On load_rise, the lane at sel is written at the next edge: q lane ← d, valid[sel] ← 1.
  - Latency: q updates 1 cycle after the cycle in which load_rise is seen.
  - Other lanes hold.
- Auto mode (auto=1):
  - sel is ignored. cur_sel = scan pointer.
  - On tick=1: lane[ptr] ← d, valid[ptr] ← 1, ptr ← ptr+1 mod 4 (3 wraps to 0).
  - load is ignored for writes, but load_prev still tracks load.
- Mode switch: ptr holds its value while auto=0. Re-entering auto resumes from the held ptr. No reset of ptr on mode change.
- wr_count increments by 1 on every write. It saturates at 2^CNT_W−1 and never wraps.
- clear=1 (no reset): q=0, valid=0, wr_count=0 at the next edge. ptr and load_prev are unaffected.
- clear and a write in the same cycle: clear wins, the write is dropped, and wr_count stays 0.
- tick and load_rise in the same cycle: mode decides. Only the action belonging to the current mode occurs.
- reset asserted mid-scan: everything returns to reset values. The first tick after release writes lane0.
- Structure: purely synchronous. One always block for registers, with combinational decode of the write enable per lane. No latches.

Test Plan:
1. Reset → q=0, valid=0000, cur_sel=0, wr_count=0. Then auto=0, sel=10, d=1, pulse load → next cycle q=0100 (WIDTH=1), valid=0100, wr_count=1.
2. Hold load=1 for 5 cycles with sel=01, d=1 → exactly one write: valid=0110, wr_count=2. Change sel while load stays high → no further writes.
3. auto=1, d alternating 1,0,1,0,1, five ticks → lanes 0..3 written, then lane0 rewritten with 1. cur_sel sequence 0,1,2,3,0,1. wr_count=5.
4. Same cycle: clear=1 and tick=1 → q=0, valid=0, wr_count=0, ptr still advances.
5. CNT_W=2, 5 writes → wr_count stops at 3.
6. Assert reset during auto scan with ptr=2 → ptr=0, q=0. The next tick writes lane0 only.
